id_issue: RTL and testbench
===========================

// Module: id_issue
// PURPOSE
//  Decode/issue stage feeding the ex stage: accepts raw RV32I instruction words over a
//  valid/ready handshake and decodes OP-IMM (0010011) and OP (0110011). Reads the
//  register file and forwards from EX and WB, then drives the registered
//  {t,st,sst,n1,n2,wa,we} bundle into ex.
//  A one-entry skid buffer absorbs downstream stalls without a combinational ready path.
// PARAMETERS
//  XLEN     32      operand/result width
//  REG_AW   5       register address width
//  T_BUBBLE 7'h00   t value meaning "no operation" to ex
// PORTS
//  clk        in   1      clock, all state updates on posedge
//  rst        in   1      synchronous reset, active-low (0 = reset)
//  inst_valid in   1      fetch presents inst
//  inst_ready out  1      stage can accept; registered
//  inst       in   32     raw instruction word
//  rs1_addr   out  REG_AW regfile read port 1 address (combinational)
//  rs2_addr   out  REG_AW regfile read port 2 address (combinational)
//  rs1_data   in   XLEN   regfile read data 1 (combinational)
//  rs2_data   in   XLEN   regfile read data 2 (combinational)
//  ex_wa/ex_we/ex_wn  in  REG_AW/1/XLEN  ex result, forward priority 1
//  wb_wa/wb_we/wb_wn  in  REG_AW/1/XLEN  writeback result, forward priority 2
//  stall      in   1      downstream cannot take new bundle; outputs hold
//  flush      in   1      discard skid and output; priority over stall
//  t_o        out  7      opcode to ex; T_BUBBLE when idle
//  st_o       out  3      funct3
//  sst_o      out  1      inst[30] (SUB/SRA select)
//  n1_o/n2_o  out  XLEN   operands
//  wa_o       out  REG_AW destination register
//  we_o       out  1      write enable
//  illegal_o  out  1      one-cycle pulse: unsupported opcode issued as bubble
// BEHAVIOUR
//  Reset (rst=0 at posedge): t_o=0, st_o=0, sst_o=0, n1_o=n2_o=0, wa_o=0, we_o=0,
//   illegal_o=0, skid empty, inst_ready=1. Reset overrides flush/stall.
//  Fire = inst_valid & inst_ready. Source instruction S = skid if skid_full, else inst.
//  rs1_addr=S[19:15], rs2_addr=S[24:20] always (even when unused).
//  Operand select per reg: if addr==0 -> 0; elif ex_we & ex_wa==addr -> ex_wn;
//   elif wb_we & wb_wa==addr -> wb_wn; else rs*_data.
//  OP-IMM: n1=rs1 val; st=funct3; st 001/101: n2={27'b0,S[24:20]}, sst=S[30];
//   else n2=sext(S[31:20]), sst=0. OP: n1=rs1 val, n2=rs2 val, sst=S[30].
//  wa=S[11:7]; we=1 only for decoded OP/OP-IMM with rd!=0.
//  Other opcode: issue bubble (t=0, we=0), illegal_o=1 for that cycle only.
//  Per posedge, rst=1, priority order:
//   flush: outputs <- bubble, skid_full<=0, inst_ready<=1; fire this cycle dropped.
//   stall: outputs hold; if fire, skid<=inst, skid_full<=1, inst_ready<=0.
//   else: if skid_full issue skid (skid_full<=0, inst_ready<=1);
//         elif fire issue inst; else outputs <- bubble.
//  Latency: 1 cycle inst-accept to t_o; 2 cycles if captured in skid.
//  Never more than one instruction held; no instruction lost or duplicated.
//  Forwarding is evaluated at issue cycle, so skid entries see current ex/wb values.
//  illegal_o cleared whenever stall holds outputs (pulse not repeated).
// STRUCTURE
//  Shared package rv_defs: OPC_OP_IMM=7'b0010011, OPC_OP=7'b0110011, T_BUBBLE,
//   funct3 constants, bundle struct {t,st,sst,n1,n2,wa,we}.
//  Sub-module id_decode: pure combinational S + operand values -> bundle + illegal.
//  Top holds skid register, ready flop, output register, forwarding muxes.
// TESTING
//  addi x1,x0,5 (0x00500093), no stall -> next cycle t=13,st=0,n1=0,n2=5,wa=1,we=1.
//  addi x2,x1,-1 with ex_we=1,ex_wa=1,ex_wn=5, rs1_data=9 -> n1=5, n2=0xFFFFFFFF.
//  srai x3,x1,4 (0x4040D193) -> st=5, sst=1, n2=4; sub x4,x1,x2 -> t=0x33, sst=1.
//  stall=1 two cycles while sending addi x5 then valid held -> first in skid,
//   inst_ready=0 next cycle, outputs held; stall=0 -> skid issues, then second inst.
//  flush with skid_full=1 -> bubble next cycle, inst_ready=1, skid content never issued.
//  lw (0x0000A083) -> bubble, we=0, illegal_o=1 for exactly one cycle; rd=x0 add -> we=0.

Source files
------------

// File: rtl/rv_defs.sv
// Shared RV32I decode definitions for the id/ex boundary: widths, opcodes,
// funct3 values and the bundle handed from the issue stage to ex.
package rv_defs;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] T_BUBBLE   = 7'h00;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef struct packed {
        logic [6:0]        t;
        logic [2:0]        st;
        logic              sst;
        logic [XLEN-1:0]   n1;
        logic [XLEN-1:0]   n2;
        logic [REG_AW-1:0] wa;
        logic              we;
    } bundle_t;

    // No-operation bundle: everything zero except the bubble opcode.
    function automatic bundle_t bubble();
        bundle_t b;
        b   = '0;
        b.t = T_BUBBLE;
        return b;
    endfunction

endpackage

// File: rtl/id_decode.sv
// Pure combinational decode of one RV32I word into the ex bundle.
// Register addresses come out here so the top can forward against them;
// the forwarded operand values come back in as v1/v2.
module id_decode
    import rv_defs::*;
(
    input  logic [31:0]       s,
    input  logic [XLEN-1:0]   v1,
    input  logic [XLEN-1:0]   v2,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    output bundle_t           b,
    output logic              illegal
);

    assign rs1_addr = s[19:15];
    assign rs2_addr = s[24:20];

    // Opcode decode; anything outside OP/OP-IMM becomes a flagged bubble.
    always_comb begin
        b       = bubble();
        illegal = 1'b0;
        case (s[6:0])
            OPC_OP_IMM: begin
                b.t  = OPC_OP_IMM;
                b.st = s[14:12];
                b.n1 = v1;
                if (s[14:12] == F3_SLL || s[14:12] == F3_SR) begin
                    // Shift-immediate: shamt only, bit 30 picks SRAI vs SRLI.
                    b.n2  = {{(XLEN-5){1'b0}}, s[24:20]};
                    b.sst = s[30];
                end else begin
                    b.n2  = {{(XLEN-12){s[31]}}, s[31:20]};
                    b.sst = 1'b0;
                end
                b.wa = s[11:7];
                b.we = |s[11:7];
            end
            OPC_OP: begin
                b.t   = OPC_OP;
                b.st  = s[14:12];
                b.sst = s[30];
                b.n1  = v1;
                b.n2  = v2;
                b.wa  = s[11:7];
                b.we  = |s[11:7];
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_issue.sv
// Decode/issue stage: valid/ready intake with a one-entry skid buffer,
// regfile read with EX/WB forwarding, and a registered bundle into ex.
// inst_ready is a flop, so stalls never form a combinational ready path.
module id_issue
    import rv_defs::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [31:0]       inst,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [REG_AW-1:0] ex_wa,
    input  logic              ex_we,
    input  logic [XLEN-1:0]   ex_wn,
    input  logic [REG_AW-1:0] wb_wa,
    input  logic              wb_we,
    input  logic [XLEN-1:0]   wb_wn,
    input  logic              stall,
    input  logic              flush,
    output logic [6:0]        t_o,
    output logic [2:0]        st_o,
    output logic              sst_o,
    output logic [XLEN-1:0]   n1_o,
    output logic [XLEN-1:0]   n2_o,
    output logic [REG_AW-1:0] wa_o,
    output logic              we_o,
    output logic              illegal_o
);

    logic [31:0]     skid;
    logic            skid_full;
    logic [31:0]     src;
    logic            fire;
    logic [XLEN-1:0] v1, v2;
    bundle_t         dec_b;
    logic            dec_ill;
    bundle_t         out_q;
    logic            ill_q;

    assign fire = inst_valid & inst_ready;
    // A held skid entry always goes first so ordering is preserved.
    assign src  = skid_full ? skid : inst;

    id_decode u_dec (
        .s        (src),
        .v1       (v1),
        .v2       (v2),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .b        (dec_b),
        .illegal  (dec_ill)
    );

    // Operand 1 forwarding: x0, then EX, then WB, then regfile.
    always_comb begin
        v1 = rs1_data;
        if (rs1_addr == '0)                     v1 = '0;
        else if (ex_we && ex_wa == rs1_addr)    v1 = ex_wn;
        else if (wb_we && wb_wa == rs1_addr)    v1 = wb_wn;
    end

    // Operand 2 forwarding, same priority as operand 1.
    always_comb begin
        v2 = rs2_data;
        if (rs2_addr == '0)                     v2 = '0;
        else if (ex_we && ex_wa == rs2_addr)    v2 = ex_wn;
        else if (wb_we && wb_wa == rs2_addr)    v2 = wb_wn;
    end

    // Skid/ready/output register update: flush beats stall beats issue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q      <= '0;
            ill_q      <= 1'b0;
            skid       <= '0;
            skid_full  <= 1'b0;
            inst_ready <= 1'b1;
        end else if (flush) begin
            out_q      <= bubble();
            ill_q      <= 1'b0;
            skid_full  <= 1'b0;
            inst_ready <= 1'b1;
        end else if (stall) begin
            // Outputs hold, but the illegal pulse must not repeat.
            ill_q <= 1'b0;
            if (fire) begin
                skid       <= inst;
                skid_full  <= 1'b1;
                inst_ready <= 1'b0;
            end
        end else if (skid_full) begin
            out_q      <= dec_b;
            ill_q      <= dec_ill;
            skid_full  <= 1'b0;
            inst_ready <= 1'b1;
        end else if (fire) begin
            out_q <= dec_b;
            ill_q <= dec_ill;
        end else begin
            out_q <= bubble();
            ill_q <= 1'b0;
        end
    end

    assign t_o       = out_q.t;
    assign st_o      = out_q.st;
    assign sst_o     = out_q.sst;
    assign n1_o      = out_q.n1;
    assign n2_o      = out_q.n2;
    assign wa_o      = out_q.wa;
    assign we_o      = out_q.we;
    assign illegal_o = ill_q;

endmodule

// File: tb/tb_id_issue.sv
// Directed bench for id_issue: hand-encoded instructions with hand-computed
// bundles, covering forwarding priority, shifts, stall/skid, flush, illegal.
module tb_id_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic [4:0]  ex_wa, wb_wa;
    logic        ex_we, wb_we;
    logic [31:0] ex_wn, wb_wn;
    logic        stall, flush;
    logic [6:0]  t_o;
    logic [2:0]  st_o;
    logic        sst_o;
    logic [31:0] n1_o, n2_o;
    logic [4:0]  wa_o;
    logic        we_o;
    logic        illegal_o;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    id_issue dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_wa(ex_wa), .ex_we(ex_we), .ex_wn(ex_wn),
        .wb_wa(wb_wa), .wb_we(wb_we), .wb_wn(wb_wn),
        .stall(stall), .flush(flush),
        .t_o(t_o), .st_o(st_o), .sst_o(sst_o), .n1_o(n1_o), .n2_o(n2_o),
        .wa_o(wa_o), .we_o(we_o), .illegal_o(illegal_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one edge and settle outputs away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; inst_valid = 1'b0; inst = 32'h0;
        rs1_data = 32'h77; rs2_data = 32'h66;
        ex_wa = 0; ex_we = 0; ex_wn = 0; wb_wa = 0; wb_we = 0; wb_wn = 0;
        stall = 0; flush = 0;
        #1;
        tick(); tick();
        chk("rst_t", {25'b0, t_o}, 32'h0);
        chk("rst_we", {31'b0, we_o}, 32'h0);
        chk("rst_n1", n1_o, 32'h0);
        chk("rst_ready", {31'b0, inst_ready}, 32'h1);
        chk("rst_ill", {31'b0, illegal_o}, 32'h0);

        // addi x1,x0,5
        rst = 1'b1; inst_valid = 1'b1; inst = 32'h00500093;
        #1;
        chk("addi_rs1a", {27'b0, rs1_addr}, 32'd0);
        chk("addi_rs2a", {27'b0, rs2_addr}, 32'd5);
        tick();
        chk("addi_t", {25'b0, t_o}, 32'h13);
        chk("addi_st", {29'b0, st_o}, 32'h0);
        chk("addi_n1", n1_o, 32'h0);
        chk("addi_n2", n2_o, 32'h5);
        chk("addi_wa", {27'b0, wa_o}, 32'h1);
        chk("addi_we", {31'b0, we_o}, 32'h1);

        // addi x2,x1,-1 with EX forwarding x1=5
        inst = 32'hFFF08113; ex_we = 1; ex_wa = 1; ex_wn = 32'd5; rs1_data = 32'd9;
        tick();
        chk("addim1_n1", n1_o, 32'h5);
        chk("addim1_n2", n2_o, 32'hFFFFFFFF);
        chk("addim1_wa", {27'b0, wa_o}, 32'h2);

        // srai x3,x1,4 ; EX beats WB on the same register
        inst = 32'h4040D193; wb_we = 1; wb_wa = 1; wb_wn = 32'hAB;
        tick();
        chk("srai_st", {29'b0, st_o}, 32'h5);
        chk("srai_sst", {31'b0, sst_o}, 32'h1);
        chk("srai_n2", n2_o, 32'h4);
        chk("srai_n1_expri", n1_o, 32'h5);

        // sub x4,x1,x2 ; WB forwards x1, regfile supplies x2
        inst = 32'h40208233; ex_we = 0; rs2_data = 32'h10;
        tick();
        chk("sub_t", {25'b0, t_o}, 32'h33);
        chk("sub_sst", {31'b0, sst_o}, 32'h1);
        chk("sub_n1_wb", n1_o, 32'hAB);
        chk("sub_n2", n2_o, 32'h10);
        wb_we = 0;

        // Stall: addi x5,x0,7 goes into skid, outputs hold
        stall = 1; inst = 32'h00700293;
        tick();
        chk("stall1_t_hold", {25'b0, t_o}, 32'h33);
        chk("stall1_wa_hold", {27'b0, wa_o}, 32'h4);
        chk("stall1_ready", {31'b0, inst_ready}, 32'h0);
        // second instruction waits on the input; skid drives the read ports
        inst = 32'h00900313;
        #1;
        chk("skid_rs2a", {27'b0, rs2_addr}, 32'd7);
        tick();
        chk("stall2_t_hold", {25'b0, t_o}, 32'h33);
        chk("stall2_ready", {31'b0, inst_ready}, 32'h0);
        stall = 0;
        tick();
        chk("skid_iss_wa", {27'b0, wa_o}, 32'h5);
        chk("skid_iss_n2", n2_o, 32'h7);
        chk("skid_iss_ready", {31'b0, inst_ready}, 32'h1);
        tick();
        chk("second_wa", {27'b0, wa_o}, 32'h6);
        chk("second_n2", n2_o, 32'h9);
        inst_valid = 0;
        tick();
        chk("idle_t", {25'b0, t_o}, 32'h0);
        chk("idle_we", {31'b0, we_o}, 32'h0);

        // Flush with a full skid: entry is discarded
        inst_valid = 1; stall = 1; inst = 32'h00300393;
        tick();
        chk("fl_skid_ready", {31'b0, inst_ready}, 32'h0);
        inst_valid = 0; stall = 0; flush = 1;
        tick();
        chk("flush_t", {25'b0, t_o}, 32'h0);
        chk("flush_we", {31'b0, we_o}, 32'h0);
        chk("flush_ready", {31'b0, inst_ready}, 32'h1);
        flush = 0;
        tick();
        chk("flush_nodup_wa", {27'b0, wa_o}, 32'h0);
        chk("flush_nodup_t", {25'b0, t_o}, 32'h0);

        // lw is unsupported: flagged bubble for exactly one cycle
        inst_valid = 1; inst = 32'h0000A083;
        tick();
        chk("lw_t", {25'b0, t_o}, 32'h0);
        chk("lw_we", {31'b0, we_o}, 32'h0);
        chk("lw_ill", {31'b0, illegal_o}, 32'h1);
        inst_valid = 0;
        tick();
        chk("lw_ill_clr", {31'b0, illegal_o}, 32'h0);

        // illegal pulse not repeated while a stall holds outputs
        inst_valid = 1; inst = 32'h0000A083;
        tick();
        chk("lw2_ill", {31'b0, illegal_o}, 32'h1);
        inst_valid = 0; stall = 1;
        tick();
        chk("lw2_stall_clr", {31'b0, illegal_o}, 32'h0);
        stall = 0;

        // add x0,x1,x2: decoded but no write
        inst_valid = 1; inst = 32'h00208033;
        tick();
        chk("addx0_t", {25'b0, t_o}, 32'h33);
        chk("addx0_we", {31'b0, we_o}, 32'h0);

        // Reset overrides an incoming instruction and a flush
        inst = 32'h00500093; rst = 0; flush = 1;
        tick();
        chk("rst2_t", {25'b0, t_o}, 32'h0);
        chk("rst2_ready", {31'b0, inst_ready}, 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
